// File: rtl/cam_capture_if.sv
// Bundle of the camera-side inputs and memory/status outputs of cam_capture.
// slave is the capture block; master is the surrounding system or bench.
interface cam_capture_if #(
  parameter int AW = 17
);
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic          capture_en;
  logic [AW-1:0] mem_px_addr;
  logic [15:0]   mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          frame_err;
  logic [7:0]    frame_cnt;

  modport slave (
    input  vsync, href, px_data, capture_en,
    output mem_px_addr, mem_px_data, px_wr, frame_done, frame_err, frame_cnt
  );

  modport master (
    output vsync, href, px_data, capture_en,
    input  mem_px_addr, mem_px_data, px_wr, frame_done, frame_err, frame_cnt
  );
endinterface

// File: rtl/cam_capture.sv
// Captures RGB565 byte pairs from a parallel camera into a frame buffer,
// converting each pixel to RGB332/RGB444/RGB565 on the fly.
module cam_capture #(
  parameter int AW    = 17,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int MODE  = 0
) (
  input  logic          pclk,
  input  logic          rst,
  cam_capture_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] BYTE_HI = 2'd2;
  localparam logic [1:0] BYTE_LO = 2'd3;

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_MAX     = XW'(IMG_W);
  localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H);
  localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);
  localparam logic [AW-1:0] NPIX      = AW'(IMG_W * IMG_H);

  logic [1:0]    state;
  logic          vsync_q;
  logic          href_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] line_base;
  logic [AW-1:0] px_count;
  logic [7:0]    hi_byte;
  logic [AW-1:0] addr_r;
  logic [15:0]   data_r;
  logic          wr_r;
  logic          done_r;
  logic          err_r;
  logic [7:0]    cnt_r;

  logic vsync_fall;
  logic vsync_rise;
  logic href_fall;
  logic in_bounds;

  assign vsync_fall = vsync_q & ~bus.vsync;
  assign vsync_rise = ~vsync_q & bus.vsync;
  assign href_fall  = href_q & ~bus.href;
  assign in_bounds  = (x < X_MAX) && (y < Y_MAX);

  // R = p[15:11], G = p[10:5], B = p[4:0]; unknown modes fall back to RGB332.
  function automatic logic [15:0] convert(input logic [15:0] p);
    case (MODE)
      1:       return {4'h0, p[15:12], p[10:7], p[4:1]};
      2:       return p;
      default: return {8'h00, p[15:13], p[10:8], p[4:3]};
    endcase
  endfunction

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours; the async reset clears every
  // register, including the output data/address, so nothing stale leaks out.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      px_count  <= '0;
      hi_byte   <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      wr_r      <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      vsync_q <= bus.vsync;
      href_q  <= bus.href;
      wr_r    <= 1'b0;
      done_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.capture_en) state <= ARMED;
        end
        ARMED: begin
          if (vsync_fall) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            px_count  <= '0;
            err_r     <= 1'b0;
            state     <= BYTE_HI;
          end
        end
        BYTE_HI, BYTE_LO: begin
          if (vsync_rise) begin
            done_r <= 1'b1;
            cnt_r  <= cnt_r + 8'd1;
            if (px_count < NPIX) err_r <= 1'b1;
            state  <= bus.capture_en ? ARMED : IDLE;
          end else if (href_fall) begin
            // An odd byte count leaves a half pixel behind: drop it and flag.
            if (state == BYTE_LO) begin
              err_r <= 1'b1;
              state <= BYTE_HI;
            end
            if (x != '0) begin
              x <= '0;
              if (y != Y_MAX) begin
                y         <= y + YW'(1);
                line_base <= line_base + LINE_STEP;
              end
            end
          end else if (bus.href) begin
            if (state == BYTE_HI) begin
              hi_byte <= bus.px_data;
              state   <= BYTE_LO;
            end else begin
              state <= BYTE_HI;
              if (in_bounds) begin
                addr_r   <= line_base + AW'(x);
                data_r   <= convert({hi_byte, bus.px_data});
                wr_r     <= 1'b1;
                px_count <= px_count + AW'(1);
              end
              if (x != X_MAX) x <= x + XW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_px_addr = addr_r;
  assign bus.mem_px_data = data_r;
  assign bus.px_wr       = wr_r;
  assign bus.frame_done  = done_r;
  assign bus.frame_err   = err_r;
  assign bus.frame_cnt   = cnt_r;

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench: three 4x2 captures (RGB332/444/565) share one camera
// stream; directed lines push expected writes/frame events, monitors pop them.
module tb_cam_capture;
  localparam int AW = 17;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  logic       capture_en;

  always #5 pclk = ~pclk;

  cam_capture_if #(.AW(AW)) bus0 ();
  cam_capture_if #(.AW(AW)) bus1 ();
  cam_capture_if #(.AW(AW)) bus2 ();

  assign bus0.vsync = vsync;  assign bus0.href = href;
  assign bus0.px_data = px_data;  assign bus0.capture_en = capture_en;
  assign bus1.vsync = vsync;  assign bus1.href = href;
  assign bus1.px_data = px_data;  assign bus1.capture_en = capture_en;
  assign bus2.vsync = vsync;  assign bus2.href = href;
  assign bus2.px_data = px_data;  assign bus2.capture_en = capture_en;

  cam_capture #(.AW(AW), .IMG_W(4), .IMG_H(2), .MODE(0)) dut0 (.pclk(pclk), .rst(rst), .bus(bus0));
  cam_capture #(.AW(AW), .IMG_W(4), .IMG_H(2), .MODE(1)) dut1 (.pclk(pclk), .rst(rst), .bus(bus1));
  cam_capture #(.AW(AW), .IMG_W(4), .IMG_H(2), .MODE(2)) dut2 (.pclk(pclk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   d0, d1, d2;
  } pix_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
  } frm_t;

  pix_t pix_q[$];
  frm_t frm_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected no event", name, act);
  endtask

  // Pixel monitor: every strobe must match the next queued write on all three.
  always @(negedge pclk) begin
    if (rst) begin
      if (bus0.px_wr) begin
        if (pix_q.size() == 0) begin
          unexpected("px_wr addr", 32'(bus0.mem_px_addr));
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("addr",        32'(bus0.mem_px_addr), 32'(e.addr));
          check("data rgb332", 32'(bus0.mem_px_data), 32'(e.d0));
          check("data rgb444", 32'(bus1.mem_px_data), 32'(e.d1));
          check("data rgb565", 32'(bus2.mem_px_data), 32'(e.d2));
          check("px_wr sync",  {30'b0, bus1.px_wr, bus2.px_wr}, 32'd3);
        end
      end else if (bus1.px_wr || bus2.px_wr) begin
        unexpected("px_wr lag", {30'b0, bus1.px_wr, bus2.px_wr});
      end
    end
  end

  // Frame monitor.
  always @(negedge pclk) begin
    if (rst && bus0.frame_done) begin
      if (frm_q.size() == 0) begin
        unexpected("frame_done cnt", 32'(bus0.frame_cnt));
      end else begin
        frm_t f;
        f = frm_q.pop_front();
        check("frame_cnt",      32'(bus0.frame_cnt), 32'(f.cnt));
        check("frame_err",      32'(bus0.frame_err), 32'(f.err));
        check("frame_cnt 565",  32'(bus2.frame_cnt), 32'(f.cnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic frame_end(input bit expect_done, input logic [7:0] cnt, input logic err);
    frm_t f;
    f.cnt = cnt;
    f.err = err;
    if (expect_done) frm_q.push_back(f);
    vsync = 1'b1;
    tick(3);
  endtask

  // Sends npx byte pairs (plus one trailing hi byte when odd); line y of a
  // live frame expects writes at y*4+i for the first 4 pixels only.
  task automatic send_line(input int npx, input logic [7:0] hi, input logic [7:0] lo,
                           input bit odd, input bit live, input int y,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    pix_t e;
    href = 1'b1;
    for (int i = 0; i < npx; i++) begin
      px_data = hi;
      tick(1);
      px_data = lo;
      if (live && i < 4 && y < 2) begin
        e.addr = AW'(y * 4 + i);
        e.d0 = d0; e.d1 = d1; e.d2 = d2;
        pix_q.push_back(e);
      end
      tick(1);
    end
    if (odd) begin
      px_data = hi;
      tick(1);
    end
    href    = 1'b0;
    px_data = 8'h00;
    tick(3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " px_wr"},      32'(bus0.px_wr), 32'd0);
    check({tag, " addr"},       32'(bus0.mem_px_addr), 32'd0);
    check({tag, " data"},       32'(bus0.mem_px_data), 32'd0);
    check({tag, " frame_done"}, 32'(bus0.frame_done), 32'd0);
    check({tag, " frame_err"},  32'(bus0.frame_err), 32'd0);
    check({tag, " frame_cnt"},  32'(bus0.frame_cnt), 32'd0);
  endtask

  initial begin
    pix_t e;
    rst = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'h00; capture_en = 1'b0;
    #3;
    check_zero("reset");
    tick(2);
    rst = 1'b1;
    tick(2);

    // Frame 1: full 4x2 frame of F8/00 (pure red).
    capture_en = 1'b1;
    tick(2);
    frame_start();
    send_line(4, 8'hF8, 8'h00, 1'b0, 1'b1, 0, 16'h00E0, 16'h0F00, 16'hF800);
    send_line(4, 8'hF8, 8'h00, 1'b0, 1'b1, 1, 16'h00E0, 16'h0F00, 16'hF800);
    frame_end(1'b1, 8'd1, 1'b0);

    // Frame 2: over-long first line is clipped, second line starts at 4.
    // 0x07FF: G[5:2]=F, B[4:1]=F -> RGB444 0x0FF; RGB332 0x1F.
    frame_start();
    send_line(6, 8'h12, 8'h34, 1'b0, 1'b1, 0, 16'h000A, 16'h014A, 16'h1234);
    send_line(4, 8'h07, 8'hFF, 1'b0, 1'b1, 1, 16'h001F, 16'h00FF, 16'h07FF);
    frame_end(1'b1, 8'd2, 1'b0);

    // Frame 3: href drops after 3 bytes, next line still lands at 4.
    frame_start();
    send_line(1, 8'hF8, 8'h00, 1'b1, 1'b1, 0, 16'h00E0, 16'h0F00, 16'hF800);
    send_line(4, 8'h07, 8'hFF, 1'b0, 1'b1, 1, 16'h001F, 16'h00FF, 16'h07FF);
    frame_end(1'b1, 8'd3, 1'b1);
    tick(4);
    check("frame_err held", 32'(bus0.frame_err), 32'd1);

    // Frame 4: capture_en drops mid-frame; frame still completes, then idle.
    frame_start();
    check("frame_err cleared", 32'(bus0.frame_err), 32'd0);
    send_line(4, 8'hF8, 8'h00, 1'b0, 1'b1, 0, 16'h00E0, 16'h0F00, 16'hF800);
    capture_en = 1'b0;
    send_line(4, 8'h12, 8'h34, 1'b0, 1'b1, 1, 16'h000A, 16'h014A, 16'h1234);
    frame_end(1'b1, 8'd4, 1'b0);
    frame_start();
    send_line(4, 8'hF8, 8'h00, 1'b0, 1'b0, 0, 16'h0, 16'h0, 16'h0);
    frame_end(1'b0, 8'd0, 1'b0);

    // Reset mid-line while a write strobe is high.
    capture_en = 1'b1;
    tick(2);
    frame_start();
    href = 1'b1;
    px_data = 8'hF8; tick(1);
    px_data = 8'h00;
    e.addr = '0; e.d0 = 16'h00E0; e.d1 = 16'h0F00; e.d2 = 16'hF800;
    pix_q.push_back(e);
    tick(1);
    px_data = 8'hF8; tick(1);
    px_data = 8'h00;
    @(posedge pclk);
    #2 rst = 1'b0;
    #1;
    check_zero("async rst");
    href = 1'b0; vsync = 1'b0; px_data = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(3);
    // Armed but no vsync edge yet: this line must not be written.
    send_line(4, 8'hF8, 8'h00, 1'b0, 1'b0, 0, 16'h0, 16'h0, 16'h0);
    frame_start();
    send_line(4, 8'h07, 8'hFF, 1'b0, 1'b1, 0, 16'h001F, 16'h00FF, 16'h07FF);
    send_line(4, 8'hF8, 8'h00, 1'b0, 1'b1, 1, 16'h00E0, 16'h0F00, 16'hF800);
    frame_end(1'b1, 8'd1, 1'b0);
    tick(4);

    check("pixel queue drained", 32'(pix_q.size()), 32'd0);
    check("frame queue drained", 32'(frm_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
